// File: rtl/serial_word_tx_if.sv
// Handshake bundle for serial_word_tx: parallel load request and word, plus the serial bit stream.
// The slave modport is the transmitter side. The master modport is the producer/consumer side.
interface serial_word_tx_if #(
    parameter int WIDTH = 16
);
    logic             st;
    logic [WIDTH-1:0] d;
    logic             srdy;
    logic             sout;
    logic             sval;
    logic             busy;
    logic             done;

    modport slave (
        input  st,
        input  d,
        input  srdy,
        output sout,
        output sval,
        output busy,
        output done
    );

    modport master (
        output st,
        output d,
        output srdy,
        input  sout,
        input  sval,
        input  busy,
        input  done
    );
endinterface

// File: rtl/serial_word_tx.sv
// Parallel-load, MSB-first serial word transmitter with a valid/ready bit handshake and a done pulse.
// Defining SERIAL_WORD_TX_PARITY_EN appends one even-parity bit after the data bits.
module serial_word_tx #(
    parameter int WIDTH = 16
) (
    input  logic           cl,
    input  logic           rst_n,
    serial_word_tx_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
`ifdef SERIAL_WORD_TX_PARITY_EN
    localparam logic [1:0] PAR   = 2'd2;
`endif
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             sout_q, sout_d;
    logic             sval_q, sval_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
`ifdef SERIAL_WORD_TX_PARITY_EN
    logic             par_q, par_d;
`endif

    // Outputs are computed for the next state so that every output comes straight from a flop.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        sout_d  = sout_q;
        sval_d  = sval_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef SERIAL_WORD_TX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.st) begin
                    state_d = SHIFT;
                    shreg_d = bus.d;
                    cnt_d   = CW'(WIDTH - 1);
                    sout_d  = bus.d[WIDTH-1];
                    sval_d  = 1'b1;
                    busy_d  = 1'b1;
`ifdef SERIAL_WORD_TX_PARITY_EN
                    par_d   = ^bus.d;
`endif
                end
            end
            SHIFT: begin
                if (bus.srdy) begin
                    shreg_d = shreg_q << 1;
                    cnt_d   = cnt_q - CW'(1);
                    sout_d  = shreg_q[WIDTH-2];
                    if (cnt_q == '0) begin
                        cnt_d   = '0;
`ifdef SERIAL_WORD_TX_PARITY_EN
                        state_d = PAR;
                        sout_d  = par_q;
`else
                        state_d = DONE;
                        sout_d  = 1'b0;
                        sval_d  = 1'b0;
                        done_d  = 1'b1;
`endif
                    end
                end
            end
`ifdef SERIAL_WORD_TX_PARITY_EN
            PAR: begin
                if (bus.srdy) begin
                    state_d = DONE;
                    sout_d  = 1'b0;
                    sval_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
`endif
            DONE: begin
                state_d = IDLE;
                sout_d  = 1'b0;
                sval_d  = 1'b0;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                shreg_d = '0;
                cnt_d   = '0;
                sout_d  = 1'b0;
                sval_d  = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Reset discards any word in flight immediately, so no done pulse can follow an abort.
    always_ff @(posedge cl or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            sout_q  <= 1'b0;
            sval_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SERIAL_WORD_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            sout_q  <= sout_d;
            sval_q  <= sval_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef SERIAL_WORD_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign bus.sout = sout_q;
    assign bus.sval = sval_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
endmodule
